// File: rtl/readout_pkg.sv
// Shared definitions for the readout deserializer: default sizes, field widths
// and the frame-receive state encoding.
package readout_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NCH_DEF   = 8;
    localparam int ADDR_W    = 3;
    localparam int EPOCH_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/readout_deserializer_if.sv
// Bundle of the serial readout stream, host controls and the deserializer's
// word/status outputs. The counter-core/host side is the master; the
// deserializer is the slave.
interface readout_deserializer_if
    import readout_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NCH   = NCH_DEF
);

    logic                serial_in;
    logic                sl;
    logic [ADDR_W-1:0]   addr;
    logic                ovf_ch;
    logic                ovf_global;
    logic                ovf_rtc;
    logic                clr;
    logic                word_valid;
    logic [WIDTH-1:0]    word_data;
    logic [ADDR_W-1:0]   word_addr;
    logic                frame_err;
    logic [ADDR_W-1:0]   rd_addr;
    logic [WIDTH-1:0]    rd_data;
    logic [NCH-1:0]      ovf_ch_flags;
    logic                ovf_global_flag;
    logic [EPOCH_W-1:0]  rtc_epoch;

    modport master (
        output serial_in, sl, addr, ovf_ch, ovf_global, ovf_rtc, clr, rd_addr,
        input  word_valid, word_data, word_addr, frame_err, rd_data,
               ovf_ch_flags, ovf_global_flag, rtc_epoch
    );

    modport slave (
        input  serial_in, sl, addr, ovf_ch, ovf_global, ovf_rtc, clr, rd_addr,
        output word_valid, word_data, word_addr, frame_err, rd_data,
               ovf_ch_flags, ovf_global_flag, rtc_epoch
    );

endinterface

// File: rtl/readout_deserializer_rx_shift.sv
// MSB-first shift register with a bit counter. `load` starts a new word with
// one bit, `shift` appends a bit, `clear` drops a partial word. `last` flags
// that the next shift completes the word; `full` flags a complete word.
module rx_shift #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word,
    output logic             last,
    output logic             full
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count;

    // Word assembly and bit counting; load takes priority over shift.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word  <= '0;
            count <= '0;
        end else if (load) begin
            word  <= WIDTH'(bit_in);
            count <= CNT_W'(1);
        end else if (shift) begin
            word  <= (word << 1) | WIDTH'(bit_in);
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(WIDTH - 1));
    assign full = (count == CNT_W'(WIDTH));

endmodule

// File: rtl/readout_deserializer.sv
// Rebuilds parallel count words from the counter core's serial readout,
// commits them to a per-channel register file, and keeps sticky overflow
// status plus an RTC epoch counter for the host.
module readout_deserializer
    import readout_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NCH   = NCH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    readout_deserializer_if.slave bus
);

    state_t              state;
    state_t              state_next;
    logic                prev_sl;
    logic                prev_rtc;
    logic [ADDR_W-1:0]   latched_addr;
    logic                load;
    logic                shift;
    logic                clear;
    logic                abort;
    logic                err;
    logic [WIDTH-1:0]    shift_word;
    logic                shift_last;
    logic                shift_full;
    logic                commit;
    logic                addr_ok;
    logic [WIDTH-1:0]    regs [NCH];
    logic [WIDTH-1:0]    word_hold;
    logic [ADDR_W-1:0]   addr_hold;
    logic [NCH-1:0]      ch_flags;
    logic [NCH-1:0]      ch_set;
    logic                global_flag;
    logic [EPOCH_W-1:0]  epoch;
    logic                rtc_rise;

    rx_shift #(.WIDTH(WIDTH)) u_rx_shift (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .shift  (shift),
        .clear  (clear),
        .bit_in (bus.serial_in),
        .word   (shift_word),
        .last   (shift_last),
        .full   (shift_full)
    );

    // State register plus the one-cycle histories used for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            prev_sl      <= 1'b0;
            prev_rtc     <= 1'b0;
            latched_addr <= '0;
            err          <= 1'b0;
        end else begin
            state    <= state_next;
            prev_sl  <= bus.sl;
            prev_rtc <= bus.ovf_rtc;
            err      <= abort;
            if (load) begin
                latched_addr <= bus.addr;
            end
        end
    end

    // Next-state and shifter control; a frame begins on a falling sl edge.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        clear      = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.sl && prev_sl) begin
                    load       = 1'b1;
                    state_next = (WIDTH == 1) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (bus.sl || (bus.addr != latched_addr)) begin
                    abort      = 1'b1;
                    clear      = 1'b1;
                    state_next = IDLE;
                end else begin
                    shift = 1'b1;
                    if (shift_last) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = bus.sl ? IDLE : WAIT;
            end
            WAIT: begin
                if (bus.sl) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign commit  = (state == DONE) && shift_full;
    assign addr_ok = int'(latched_addr) < NCH;

    // Register file write; out-of-range channels are announced but not stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && addr_ok) begin
            regs[latched_addr] <= shift_word;
        end
    end

    // Hold the last committed word and channel between commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_hold <= '0;
            addr_hold <= '0;
        end else if (commit) begin
            word_hold <= shift_word;
            addr_hold <= latched_addr;
        end
    end

    // Channel-overflow set mask for the word being committed this cycle.
    always_comb begin
        ch_set = '0;
        if (commit && addr_ok) begin
            ch_set[latched_addr] = bus.ovf_ch;
        end
    end

    assign rtc_rise = bus.ovf_rtc && !prev_rtc;

    // Sticky status; a set or increment in the same cycle as clr wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_flags    <= '0;
            global_flag <= 1'b0;
            epoch       <= '0;
        end else begin
            ch_flags    <= (bus.clr ? '0 : ch_flags) | ch_set;
            global_flag <= bus.ovf_global || (global_flag && !bus.clr);
            epoch       <= (bus.clr ? '0 : epoch) + EPOCH_W'(rtc_rise);
        end
    end

    assign bus.word_valid      = commit;
    assign bus.word_data       = commit ? shift_word : word_hold;
    assign bus.word_addr       = commit ? latched_addr : addr_hold;
    assign bus.frame_err       = err;
    assign bus.rd_data         = (int'(bus.rd_addr) < NCH) ? regs[bus.rd_addr] : '0;
    assign bus.ovf_ch_flags    = ch_flags;
    assign bus.ovf_global_flag = global_flag;
    assign bus.rtc_epoch       = epoch;

endmodule

// File: tb/tb_readout_deserializer.sv
// Bench for readout_deserializer: directed scenarios followed by randomized
// frames, every cycle compared against a queue-based frame model.
module tb_readout_deserializer;
    import readout_pkg::*;

    localparam int W  = 16;
    localparam int NC = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    readout_deserializer_if #(.WIDTH(W), .NCH(NC)) bus ();

    readout_deserializer #(.WIDTH(W), .NCH(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;
    int dut_valids = 0;
    int dut_errs = 0;
    bit rand_side = 1'b0;

    // Reference model state: words are collected as a queue of bits.
    logic [W-1:0] ref_mem [NC];
    bit           ref_bits [$];
    bit           ref_prev_sl;
    bit           ref_prev_rtc;
    bit           ref_ignoring;
    bit           ref_commit_due;
    bit           ref_err;
    logic [W-1:0] ref_word;
    logic [W-1:0] ref_last_word;
    logic [2:0]   ref_addr;
    logic [2:0]   ref_last_addr;
    logic [NC-1:0] ref_flags;
    bit           ref_gflag;
    logic [7:0]   ref_epoch;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic finish_word();
        ref_word = '0;
        foreach (ref_bits[i]) ref_word = (ref_word << 1) | W'(ref_bits[i]);
        ref_bits.delete();
        ref_commit_due = 1'b1;
    endtask

    task automatic model_step();
        logic [NC-1:0] setm;
        bit rise;
        if (reset) begin
            for (int i = 0; i < NC; i++) ref_mem[i] = '0;
            ref_bits.delete();
            ref_prev_sl = 0; ref_prev_rtc = 0; ref_ignoring = 0;
            ref_commit_due = 0; ref_err = 0;
            ref_word = '0; ref_last_word = '0; ref_addr = '0; ref_last_addr = '0;
            ref_flags = '0; ref_gflag = 0; ref_epoch = '0;
            return;
        end
        setm = '0;
        ref_err = 0;
        if (ref_commit_due) begin
            ref_commit_due = 0;
            ref_last_word = ref_word;
            ref_last_addr = ref_addr;
            if (int'(ref_addr) < NC) begin
                ref_mem[ref_addr] = ref_word;
                if (bus.ovf_ch) setm[ref_addr] = 1'b1;
            end
            ref_ignoring = !bus.sl;
        end else if (ref_bits.size() != 0) begin
            if (bus.sl || bus.addr != ref_addr) begin
                ref_err = 1;
                ref_bits.delete();
            end else begin
                ref_bits.push_back(bus.serial_in);
                if (ref_bits.size() == W) finish_word();
            end
        end else if (ref_ignoring) begin
            if (bus.sl) ref_ignoring = 0;
        end else if (!bus.sl && ref_prev_sl) begin
            ref_addr = bus.addr;
            ref_bits.push_back(bus.serial_in);
            if (ref_bits.size() == W) finish_word();
        end
        rise = bus.ovf_rtc && !ref_prev_rtc;
        if (bus.clr) begin
            ref_flags = setm;
            ref_gflag = bus.ovf_global;
            ref_epoch = rise ? 8'd1 : 8'd0;
        end else begin
            ref_flags = ref_flags | setm;
            ref_gflag = ref_gflag || bus.ovf_global;
            ref_epoch = ref_epoch + 8'(rise);
        end
        ref_prev_sl = bus.sl;
        ref_prev_rtc = bus.ovf_rtc;
    endtask

    task automatic check_outputs();
        chk("word_valid", 32'(bus.word_valid), 32'(ref_commit_due));
        chk("word_data", 32'(bus.word_data), 32'(ref_commit_due ? ref_word : ref_last_word));
        chk("word_addr", 32'(bus.word_addr), 32'(ref_commit_due ? ref_addr : ref_last_addr));
        chk("frame_err", 32'(bus.frame_err), 32'(ref_err));
        chk("rd_data", 32'(bus.rd_data), 32'(ref_mem[bus.rd_addr]));
        chk("ovf_ch_flags", 32'(bus.ovf_ch_flags), 32'(ref_flags));
        chk("ovf_global_flag", 32'(bus.ovf_global_flag), 32'(ref_gflag));
        chk("rtc_epoch", 32'(bus.rtc_epoch), 32'(ref_epoch));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        if (bus.word_valid === 1'b1) dut_valids++;
        if (bus.frame_err === 1'b1) dut_errs++;
    endtask

    task automatic drive(input bit s, input bit d, input logic [2:0] a);
        if (rand_side) begin
            bus.ovf_ch     = 1'($urandom_range(0, 1));
            bus.ovf_global = ($urandom_range(0, 15) == 0);
            bus.ovf_rtc    = 1'($urandom_range(0, 1));
            bus.clr        = ($urandom_range(0, 19) == 0);
            bus.rd_addr    = 3'($urandom_range(0, 7));
        end
        bus.sl = s;
        bus.serial_in = d;
        bus.addr = a;
        cycle();
    endtask

    task automatic send_bits(input logic [W-1:0] d, input logic [2:0] a, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, d[W-1-i], a);
    endtask

    initial begin
        int v0;
        int e0;
        bus.serial_in = 0; bus.sl = 0; bus.addr = 0; bus.ovf_ch = 0;
        bus.ovf_global = 0; bus.ovf_rtc = 0; bus.clr = 0; bus.rd_addr = 0;
        reset = 1'b1;
        repeat (3) cycle();
        chk("reset_valid", 32'(bus.word_valid), 32'd0);
        chk("reset_data", 32'(bus.word_data), 32'd0);
        reset = 1'b0;

        // sl low from reset: no frame may start without an observed load
        for (int i = 0; i < 20; i++) drive(1'b0, 1'($urandom_range(0, 1)), 3'd2);
        chk("no_frame_after_reset", 32'(dut_valids), 32'd0);

        // basic frame 0xA5C3 at channel 2
        bus.rd_addr = 3'd2;
        drive(1'b1, 1'b0, 3'd2);
        drive(1'b1, 1'b0, 3'd2);
        send_bits(16'hA5C3, 3'd2, 16);
        chk("a5c3_valid", 32'(bus.word_valid), 32'd1);
        chk("a5c3_data", 32'(bus.word_data), 32'hA5C3);
        chk("a5c3_addr", 32'(bus.word_addr), 32'd2);
        drive(1'b1, 1'b0, 3'd2);
        chk("a5c3_rd", 32'(bus.rd_data), 32'hA5C3);

        // sl rises after 7 bits: single error pulse, slot untouched
        send_bits(16'h1234, 3'd2, 7);
        drive(1'b1, 1'b0, 3'd2);
        chk("abort_err", 32'(bus.frame_err), 32'd1);
        drive(1'b1, 1'b0, 3'd2);
        chk("abort_err_once", 32'(bus.frame_err), 32'd0);
        chk("abort_slot", 32'(bus.rd_data), 32'hA5C3);
        send_bits(16'h5A3C, 3'd2, 16);
        drive(1'b1, 1'b0, 3'd2);
        chk("after_abort_rd", 32'(bus.rd_data), 32'h5A3C);

        // address changes 3 -> 4 mid-frame
        v0 = dut_valids;
        bus.rd_addr = 3'd3;
        send_bits(16'hFFFF, 3'd3, 8);
        drive(1'b0, 1'b1, 3'd4);
        chk("addr_chg_err", 32'(bus.frame_err), 32'd1);
        drive(1'b0, 1'b1, 3'd4);
        chk("addr_chg_nocommit", 32'(dut_valids - v0), 32'd0);
        chk("addr_chg_slot", 32'(bus.rd_data), 32'd0);

        // channel 7 frame with channel overflow on the commit cycle
        drive(1'b1, 1'b0, 3'd7);
        send_bits(16'hBEEF, 3'd7, 16);
        bus.ovf_ch = 1'b1;
        drive(1'b1, 1'b0, 3'd7);
        bus.ovf_ch = 1'b0;
        chk("ovf_ch_flag7", 32'(bus.ovf_ch_flags), 32'h80);

        // global flag set then cleared
        bus.ovf_global = 1'b1; cycle(); bus.ovf_global = 1'b0;
        chk("gflag_set", 32'(bus.ovf_global_flag), 32'd1);
        bus.clr = 1'b1; cycle(); bus.clr = 1'b0;
        chk("gflag_clr", 32'(bus.ovf_global_flag), 32'd0);
        chk("chflag_clr", 32'(bus.ovf_ch_flags), 32'd0);

        // 256 RTC rising edges wrap the epoch, then clr + rise gives 1
        for (int i = 0; i < 256; i++) begin
            bus.ovf_rtc = 1'b1; cycle();
            bus.ovf_rtc = 1'b0; cycle();
        end
        chk("epoch_wrap", 32'(bus.rtc_epoch), 32'd0);
        bus.clr = 1'b1; bus.ovf_rtc = 1'b1; cycle();
        bus.clr = 1'b0; bus.ovf_rtc = 1'b0;
        chk("epoch_clr_rise", 32'(bus.rtc_epoch), 32'd1);

        // reset at bit 9 of a frame
        v0 = dut_valids; e0 = dut_errs;
        bus.rd_addr = 3'd2;
        drive(1'b1, 1'b0, 3'd1);
        send_bits(16'hC0DE, 3'd1, 9);
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("rst_mid_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_mid_data", 32'(bus.word_data), 32'd0);
        chk("rst_mid_rd", 32'(bus.rd_data), 32'd0);
        chk("rst_mid_epoch", 32'(bus.rtc_epoch), 32'd0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'($urandom_range(0, 1)), 3'd1);
        chk("rst_mid_events", 32'((dut_valids - v0) + (dut_errs - e0)), 32'd0);

        // 20 trailing sl==0 cycles after a commit
        v0 = dut_valids; e0 = dut_errs;
        drive(1'b1, 1'b0, 3'd5);
        send_bits(16'h0F0F, 3'd5, 16);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'($urandom_range(0, 1)), 3'd5);
        drive(1'b1, 1'b0, 3'd5);
        chk("trail_one_valid", 32'(dut_valids - v0), 32'd1);
        chk("trail_no_err", 32'(dut_errs - e0), 32'd0);

        // randomized frames, aborts and side-band activity
        rand_side = 1'b1;
        for (int f = 0; f < 40; f++) begin
            logic [2:0] a;
            logic [W-1:0] d;
            int kind;
            int cut;
            a = 3'($urandom_range(0, 7));
            d = W'($urandom);
            kind = $urandom_range(0, 9);
            cut = $urandom_range(1, W - 1);
            for (int i = 0; i < $urandom_range(1, 3); i++) drive(1'b1, 1'b0, a);
            if (kind < 7) begin
                send_bits(d, a, W);
            end else if (kind < 9) begin
                send_bits(d, a, cut);
                drive(1'b1, 1'b0, a);
            end else begin
                send_bits(d, a, cut);
                drive(1'b0, 1'b0, a + 3'd1);
            end
            for (int i = 0; i < $urandom_range(0, 3); i++) drive(1'b0, 1'($urandom_range(0, 1)), a);
        end
        rand_side = 1'b0;
        bus.clr = 1'b0; bus.ovf_rtc = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
